core_ex_dmem_resp: RTL and testbench

CORE_EX_DMEM_RESP -- requirements
Module: core_ex_dmem_resp

---
 rtl/core_ex_dmem_resp_pkg.sv | 32 +++
 rtl/core_dmem_array.sv | 32 +++
 rtl/core_ex_dmem_resp.sv | 140 ++++++++++++++
 tb/tb_core_ex_dmem_resp.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ex_dmem_resp_pkg.sv
// Shared LSU encodings, FSM states and helpers for the execute-stage data memory responder.
package core_ex_dmem_resp_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned CNT_W    = 2;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

  // Natural alignment check for a load of the given size at byte offset off.
  function automatic logic load_misaligned(input lsu_size_e size, input logic [2:0] off);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/core_dmem_array.sv
// DEPTH x XLEN data storage with byte-lane write enables and combinational read.
module core_dmem_array
  import core_ex_dmem_resp_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = 512,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned LANES = XLEN / 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LANES-1:0] be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [XLEN-1:0]  rdata_c
);

  logic [XLEN-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (be[l]) mem[waddr][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/core_ex_dmem_resp.sv
// Single-outstanding data memory responder: captures an LSU request, commits stores
// immediately, and returns the extended load result after a fixed latency.
module core_ex_dmem_resp
  import core_ex_dmem_resp_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wmask,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned     LANES      = XLEN / 8;
  localparam int unsigned     IDX_W      = $clog2(DEPTH);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(DEPTH) << 3;

  resp_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept_c;

  logic [IDX_W-1:0] idx_c;
  logic [XLEN-1:0]  word_c;
  logic [XLEN-1:0]  shifted_c;
  logic [XLEN-1:0]  load_c;
  logic             sext_c;
  logic             range_err_c;
  logic             err_c;
  logic             we_c;

  // Store masks must be empty or one naturally aligned group of 1/2/4/8 lanes.
  function automatic logic mask_ok(input logic [LANES-1:0] m);
    logic ok;
    ok = (m == '0);
    for (int unsigned g = 1; g <= 8 && g <= LANES; g = g * 2) begin
      for (int unsigned o = 0; o + g <= LANES; o = o + g) begin
        if (m == LANES'(((64'd1 << g) - 64'd1) << o)) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  assign idx_c       = req_addr[IDX_W+2:3];
  assign range_err_c = (req_addr >= ADDR_LIMIT);
  assign err_c       = range_err_c
                     | (req_wen ? ~mask_ok(req_wmask)
                                : load_misaligned(lsu_size_e'(req_size), req_addr[2:0]));
  assign we_c        = accept_c & req_wen & ~err_c & ~rst;

  core_dmem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (we_c),
    .be      (req_wmask),
    .waddr   (idx_c),
    .wdata   (req_wdata),
    .raddr   (idx_c),
    .rdata_c (word_c)
  );

  assign shifted_c = word_c >> {req_addr[2:0], 3'b000};
  assign sext_c    = ~req_unsigned;

  // Truncate to the access size, then sign- or zero-extend.
  always_comb begin
    load_c = shifted_c;
    case (lsu_size_e'(req_size))
      SIZE_B:  load_c = {{(XLEN-8){sext_c & shifted_c[7]}},   shifted_c[7:0]};
      SIZE_H:  load_c = {{(XLEN-16){sext_c & shifted_c[15]}}, shifted_c[15:0]};
      SIZE_W:  load_c = {{(XLEN-32){sext_c & shifted_c[31]}}, shifted_c[31:0]};
      default: load_c = shifted_c;
    endcase
  end

  // Next-state logic; WAIT is left on the edge where the count reaches zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_c = 1'b1;
          if (LATENCY <= 1) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt_next == '0) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == ST_IDLE);
      rsp_valid <= (state_next == ST_RESP);
      if (accept_c) begin
        rsp_rdata <= (req_wen || err_c) ? '0 : load_c;
        rsp_err   <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_core_ex_dmem_resp.sv
// Scoreboard bench for core_ex_dmem_resp at LATENCY 2 (main), 1 and 4.
module tb_core_ex_dmem_resp;

  localparam int unsigned DEPTH = 512;
  localparam int          NDUT  = 3;
  localparam int          TMO   = 50;

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst          [NDUT];
  logic        req_valid    [NDUT];
  logic        req_ready    [NDUT];
  logic [63:0] req_addr     [NDUT];
  logic        req_wen      [NDUT];
  logic [63:0] req_wdata    [NDUT];
  logic [7:0]  req_wmask    [NDUT];
  logic [1:0]  req_size     [NDUT];
  logic        req_unsigned [NDUT];
  logic        rsp_valid    [NDUT];
  logic        rsp_ready    [NDUT];
  logic [63:0] rsp_rdata    [NDUT];
  logic        rsp_err      [NDUT];

  logic [63:0] mdl [NDUT][DEPTH];
  exp_t        sbq [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    core_ex_dmem_resp #(
      .XLEN    (64),
      .DEPTH   (DEPTH),
      .LATENCY ((i == 0) ? 2 : ((i == 1) ? 1 : 4))
    ) u_dut (
      .clk          (clk),
      .rst          (rst[i]),
      .req_valid    (req_valid[i]),
      .req_ready    (req_ready[i]),
      .req_addr     (req_addr[i]),
      .req_wen      (req_wen[i]),
      .req_wdata    (req_wdata[i]),
      .req_wmask    (req_wmask[i]),
      .req_size     (req_size[i]),
      .req_unsigned (req_unsigned[i]),
      .rsp_valid    (rsp_valid[i]),
      .rsp_ready    (rsp_ready[i]),
      .rsp_rdata    (rsp_rdata[i]),
      .rsp_err      (rsp_err[i])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic bench_mask_ok(input logic [7:0] m);
    int n;
    int lo;
    logic [7:0] grp;
    n = $countones(m);
    if (n == 0) return 1'b1;
    if (!(n == 1 || n == 2 || n == 4 || n == 8)) return 1'b0;
    lo = 0;
    while (!m[lo]) lo++;
    if (lo % n != 0) return 1'b0;
    grp = 8'(((1 << n) - 1) << lo);
    return m == grp;
  endfunction

  // Reference behaviour; also applies a legal store to the model memory.
  task automatic model_req(input int d, input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask,
                           input logic [1:0] size, input logic uns, output exp_t e);
    logic [63:0] sh;
    logic [63:0] keep;
    int idx;
    int nb;
    e = '0;
    if (addr >= 64'(DEPTH * 8)) begin
      e.err = 1'b1;
      return;
    end
    idx = int'(addr >> 3);
    if (wen) begin
      if (!bench_mask_ok(wmask)) e.err = 1'b1;
      else for (int l = 0; l < 8; l++) if (wmask[l]) mdl[d][idx][8*l +: 8] = wdata[8*l +: 8];
      return;
    end
    nb = 1 << size;
    if (int'(addr[2:0]) % nb != 0) begin
      e.err = 1'b1;
      return;
    end
    sh = mdl[d][idx] >> (8 * int'(addr[2:0]));
    if (nb < 8) begin
      keep = (64'd1 << (8 * nb)) - 64'd1;
      sh = sh & keep;
      if (!uns && sh[8*nb-1]) sh = sh | ~keep;
    end
    e.rdata = sh;
  endtask

  // One request/response transaction; hold>0 stalls rsp_ready for that many cycles.
  task automatic do_req(input int d, input string tag, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask, input logic [1:0] size,
                        input logic uns, input int hold);
    exp_t e;
    int n;
    int lat;
    model_req(d, wen, addr, wdata, wmask, size, uns, e);
    sbq.push_back(e);
    rsp_ready[d]    = (hold == 0);
    req_wen[d]      = wen;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    req_wmask[d]    = wmask;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_valid[d]    = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TMO) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(lat_of(d)));
    if (hold > 0) begin
      req_valid[d] = 1'b1;
      req_wen[d]   = 1'b0;
      req_addr[d]  = 64'hFFFF_0000;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 64'(rsp_valid[d]), 64'd1);
        check({tag, "_hold_rdata"}, rsp_rdata[d], sbq[0].rdata);
        check({tag, "_hold_ready"}, 64'(req_ready[d]), 64'd0);
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
    end
    e = sbq.pop_front();
    check({tag, "_rdata"}, rsp_rdata[d], e.rdata);
    check({tag, "_err"}, 64'(rsp_err[d]), 64'(e.err));
    @(posedge clk); #1;
    check({tag, "_done"}, 64'({rsp_valid[d], req_ready[d]}), 64'd1);
  endtask

  // Continuous requests with rsp_ready=1: accepts must be LATENCY+1 cycles apart.
  task automatic spacing(input int d);
    int last;
    int nacc;
    int lat;
    lat  = lat_of(d);
    last = -1;
    nacc = 0;
    rsp_ready[d]    = 1'b1;
    req_wen[d]      = 1'b0;
    req_addr[d]     = 64'h40;
    req_wdata[d]    = 64'd0;
    req_wmask[d]    = 8'h00;
    req_size[d]     = 2'd3;
    req_unsigned[d] = 1'b0;
    req_valid[d]    = 1'b1;
    for (int c = 0; c < 80 && nacc < 5; c++) begin
      if (req_ready[d] === 1'b1) begin
        if (last >= 0) check($sformatf("spacing_L%0d", lat), 64'(c - last), 64'(lat + 1));
        last = c;
        nacc++;
      end
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
    check($sformatf("spacing_L%0d_count", lat), 64'(nacc), 64'd5);
    repeat (lat + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t dummy;
    for (int d = 0; d < NDUT; d++) begin
      rst[d]          = 1'b1;
      req_valid[d]    = 1'b0;
      req_addr[d]     = 64'd0;
      req_wen[d]      = 1'b0;
      req_wdata[d]    = 64'd0;
      req_wmask[d]    = 8'h00;
      req_size[d]     = 2'd0;
      req_unsigned[d] = 1'b0;
      rsp_ready[d]    = 1'b1;
      for (int w = 0; w < DEPTH; w++) mdl[d][w] = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b0;
      check($sformatf("rst%0d_req_ready", d), 64'(req_ready[d]), 64'd1);
      check($sformatf("rst%0d_rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
      check($sformatf("rst%0d_rsp_rdata", d), rsp_rdata[d], 64'd0);
      check($sformatf("rst%0d_rsp_err", d), 64'(rsp_err[d]), 64'd0);
    end

    // Main instance, LATENCY=2
    do_req(0, "st_d",      1'b1, 64'h10,  64'h1122334455667788, 8'hFF, 2'd3, 1'b0, 0);
    do_req(0, "ld_d",      1'b0, 64'h10,  64'd0, 8'h00, 2'd3, 1'b0, 0);
    do_req(0, "ld_b_s",    1'b0, 64'h17,  64'd0, 8'h00, 2'd0, 1'b0, 0);
    do_req(0, "st_b",      1'b1, 64'h17,  64'h8000_0000_0000_0000, 8'h80, 2'd0, 1'b0, 0);
    do_req(0, "ld_b_s80",  1'b0, 64'h17,  64'd0, 8'h00, 2'd0, 1'b0, 0);
    do_req(0, "ld_b_u80",  1'b0, 64'h17,  64'd0, 8'h00, 2'd0, 1'b1, 0);
    do_req(0, "ld_w_mis",  1'b0, 64'h12,  64'd0, 8'h00, 2'd2, 1'b0, 0);
    do_req(0, "ld_oor",    1'b0, 64'(DEPTH * 8), 64'd0, 8'h00, 2'd3, 1'b0, 0);
    do_req(0, "st_badmsk", 1'b1, 64'h10,  64'hFFFF_FFFF_FFFF_FFFF, 8'h06, 2'd0, 1'b0, 0);
    do_req(0, "ld_unchg",  1'b0, 64'h10,  64'd0, 8'h00, 2'd3, 1'b0, 0);
    do_req(0, "st_w_hi",   1'b1, 64'h20,  64'hA5A5_1234_0000_0000, 8'hF0, 2'd2, 1'b0, 0);
    do_req(0, "ld_w_u",    1'b0, 64'h24,  64'd0, 8'h00, 2'd2, 1'b1, 0);
    do_req(0, "ld_w_s",    1'b0, 64'h24,  64'd0, 8'h00, 2'd2, 1'b0, 0);
    do_req(0, "st_h",      1'b1, 64'h22,  64'h0000_0000_8001_0000, 8'h0C, 2'd1, 1'b0, 0);
    do_req(0, "ld_h_s",    1'b0, 64'h22,  64'd0, 8'h00, 2'd1, 1'b0, 0);
    do_req(0, "ld_h_mis",  1'b0, 64'h21,  64'd0, 8'h00, 2'd1, 1'b0, 0);
    do_req(0, "st_nop",    1'b1, 64'h20,  64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'd3, 1'b0, 0);
    do_req(0, "st_h2",     1'b1, 64'h20,  64'h0000_BEEF_0000_0000, 8'h30, 2'd1, 1'b0, 0);
    do_req(0, "st_unal",   1'b1, 64'h20,  64'hFFFF_FFFF_FFFF_FFFF, 8'h18, 2'd1, 1'b0, 0);
    do_req(0, "ld_w_mix",  1'b0, 64'h24,  64'd0, 8'h00, 2'd2, 1'b1, 0);
    do_req(0, "ld_d_mix",  1'b0, 64'h20,  64'd0, 8'h00, 2'd3, 1'b0, 0);
    do_req(0, "st_last",   1'b1, 64'hFF8, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 2'd3, 1'b0, 0);
    do_req(0, "ld_last",   1'b0, 64'hFF8, 64'd0, 8'h00, 2'd3, 1'b0, 0);
    do_req(0, "ld_b_last", 1'b0, 64'hFFF, 64'd0, 8'h00, 2'd0, 1'b1, 0);
    do_req(0, "st_oor",    1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd3, 1'b0, 0);
    do_req(0, "hold",      1'b0, 64'h10,  64'd0, 8'h00, 2'd3, 1'b0, 5);

    // Reset while an accepted store is waiting: response dropped, store kept
    model_req(0, 1'b1, 64'h30, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2'd3, 1'b0, dummy);
    req_wen[0]   = 1'b1;
    req_addr[0]  = 64'h30;
    req_wdata[0] = 64'hDEAD_BEEF_CAFE_F00D;
    req_wmask[0] = 8'hFF;
    req_valid[0] = 1'b1;
    check("rstwait_ready_before", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("rstwait_no_rsp", 64'(rsp_valid[0]), 64'd0);
      @(posedge clk); #1;
    end
    check("rstwait_ready_after", 64'(req_ready[0]), 64'd1);
    do_req(0, "ld_after_rst", 1'b0, 64'h30, 64'd0, 8'h00, 2'd3, 1'b0, 0);
    spacing(0);

    // LATENCY=1 and LATENCY=4 instances
    for (int d = 1; d < NDUT; d++) begin
      do_req(d, $sformatf("d%0d_st", d), 1'b1, 64'h40, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'd3, 1'b0, 0);
      do_req(d, $sformatf("d%0d_ld_h", d), 1'b0, 64'h46, 64'd0, 8'h00, 2'd1, 1'b0, 0);
      do_req(d, $sformatf("d%0d_ld_hold", d), 1'b0, 64'h40, 64'd0, 8'h00, 2'd3, 1'b0, 3);
      spacing(d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
